// File: rtl/dmem_dma.sv
// +----------------------------------------------------------------------------+
// | dmem_dma : word-by-word block copy engine on the data-memory port.         |
// | Optional: DMA_CSUM_EN adds a running 32-bit sum of the words read.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_dma #(
  parameter int MEM_WORDS = 45100,
  parameter int LEN_W     = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic [31:0]      csum
);

  localparam logic [2:0]  c_ST_IDLE  = 3'd0;
  localparam logic [2:0]  c_ST_CHECK = 3'd1;
  localparam logic [2:0]  c_ST_READ  = 3'd2;
  localparam logic [2:0]  c_ST_WRITE = 3'd3;
  localparam logic [2:0]  c_ST_FIN   = 3'd4;
  localparam logic [32:0] c_MEM_END  = 33'(MEM_WORDS);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_words;
  logic [31:0]      r_data;
  logic             r_err;

  // End addresses are formed at 33 bits so a huge base cannot wrap into range.
  logic [32:0]      w_src_end;
  logic [32:0]      w_dst_end;
  logic             w_range_err;
  logic [LEN_W-1:0] w_words_inc;
  logic             w_last;
  logic [31:0]      w_offset;

  assign w_src_end   = {1'b0, r_src} + 33'(r_len);
  assign w_dst_end   = {1'b0, r_dst} + 33'(r_len);
  assign w_range_err = (w_src_end > c_MEM_END) || (w_dst_end > c_MEM_END);
  assign w_words_inc = r_words + LEN_W'(1);
  assign w_last      = (w_words_inc == r_len);
  assign w_offset    = 32'(r_words);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (start) w_state_nxt = c_ST_CHECK;
      c_ST_CHECK: begin
        if (w_range_err || (r_len == '0)) w_state_nxt = c_ST_FIN;
        else                              w_state_nxt = c_ST_READ;
      end
      c_ST_READ:  w_state_nxt = c_ST_WRITE;
      c_ST_WRITE: w_state_nxt = w_last ? c_ST_FIN : c_ST_READ;
      c_ST_FIN:   w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    mem_we = 1'b0;
    mem_a  = '0;
    case (r_state)
      c_ST_CHECK: busy = 1'b1;
      c_ST_READ: begin
        busy  = 1'b1;
        mem_a = r_src + w_offset;
      end
      c_ST_WRITE: begin
        busy   = 1'b1;
        mem_a  = r_dst + w_offset;
        mem_we = !rst;
      end
      c_ST_FIN: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_src   <= src_addr;
            r_dst   <= dst_addr;
            r_len   <= len;
            r_words <= '0;
            r_err   <= 1'b0;
          end
        end
        c_ST_CHECK: if (w_range_err) r_err <= 1'b1;
        c_ST_READ:  r_data  <= mem_rd;
        c_ST_WRITE: r_words <= w_words_inc;
        default: ;
      endcase
    end
  end

  assign err        = r_err;
  assign words_done = r_words;
  assign mem_wd     = r_data;

`ifdef DMA_CSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_csum <= '0;
    end else if ((r_state == c_ST_IDLE) && start) begin
      r_csum <= '0;
    end else if (r_state == c_ST_READ) begin
      r_csum <= r_csum + mem_rd;
    end
  end

  assign csum = r_csum;
`else
  assign csum = '0;
`endif

endmodule

`default_nettype wire

// File: doc/dmem_dma.md
Name: dmem_dma

Overview:
- Block-copy initiator that drives the data-memory port: clk, we, 32-bit address, 32-bit write data and 32-bit read data.
- The memory reads combinationally: rd follows the address in the same cycle.
- The memory commits writes on the falling edge of clk.
- Copies len consecutive words from src_addr to dst_addr, one read cycle and one write cycle per word.
- Used by the CPU-side control logic to move image/data buffers without stalling the core pipeline.

Parameters:
- MEM_WORDS, 45100, number of addressable words in data memory; the valid address range is 0..MEM_WORDS-1.
- LEN_W, 18, width of the length and progress counters; matches the 18-bit memory index.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request pulse; sampled only in IDLE.
- src_addr  in  32  first source word address.
- dst_addr  in  32  first destination word address.
- len  in  LEN_W  number of words to copy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  range error flag; sticky until the next accepted start.
- words_done  out  LEN_W  count of words written in the current transfer.
- mem_we  out  1  write enable to data memory.
- mem_a  out  32  address to data memory.
- mem_wd  out  32  write data to data memory.
- mem_rd  in  32  read data from data memory (combinational).
- csum  out  32  running checksum; only active with DMA_CSUM_EN.

Behaviour:
- Reset: state=IDLE; busy, done, err, mem_we = 0; mem_a, mem_wd, words_done, csum = 0.
- mem_we is gated combinationally by !rst, so no memory write occurs during a reset cycle. This applies even when reset lands mid-WRITE.
- States: IDLE, CHECK, READ, WRITE, FIN.
- IDLE:
  - On start=1, latch src_addr, dst_addr and len into internal registers.
  - Clear err, words_done and csum; go to CHECK.
  - start is ignored in every state other than IDLE.
- CHECK (1 cycle, no memory access):
  - Compute src+len and dst+len at 33 bits; there is no wraparound.
  - If either sum > MEM_WORDS: set err=1 and go to FIN.
  - Else if len==0: go to FIN with err=0.
  - Else go to READ.
- READ:
  - mem_a = src + words_done; mem_we=0.
  - At the rising edge, capture mem_rd into the data register; go to WRITE.
- WRITE:
  - mem_a = dst + words_done; mem_wd = data register; mem_we=1. The memory commits at the falling edge.
  - At the rising edge, words_done increments by 1.
  - If words_done+1 == len, go to FIN; else go to READ.
- FIN: done=1 for exactly one cycle, then go to IDLE. busy is low in FIN.
- Outside READ and WRITE: mem_we=0 and mem_a=0; mem_wd holds its last value.
- Addresses ascend strictly.
  - For overlapping regions with dst > src, the result is the defined forward-copy outcome, i.e. the source pattern is smeared forward.
  - No overlap detection is performed.
- Latency, with the start cycle as cycle 0:
  - CHECK at cycle 1.
  - Word k: READ at cycle 2+2k, WRITE at cycle 3+2k.
  - done at cycle 2+2*len; len==0 or a range error gives done at cycle 2.
- Back-to-back transfers: start is accepted in the cycle after done, when the block is back in IDLE.
- words_done, err and csum hold their final values until the next accepted start.

Optional Feature:
- Macro: DMA_CSUM_EN.
- With the macro defined:
  - In each READ cycle, csum <= csum + mem_rd, modulo 2^32.
  - csum is cleared on an accepted start and is valid when done pulses.
- Without the macro: csum is tied to 0 and no adder is synthesized.

Test Plan:
- Basic copy: preload RAM[100..103]=1,2,3,4; start with src=100, dst=200, len=4.
  - done at cycle 10; RAM[200..203]=1,2,3,4; words_done=4; err=0.
  - With DMA_CSUM_EN, csum=10.
- Zero length: len=0.
  - done at cycle 2; mem_we never asserted; err=0; words_done=0.
- Range error: src=45098, len=3.
  - err=1 and done at cycle 2; no mem_we pulse; err clears on the next valid start.
- Boundary: src=0, dst=45099, len=1.
  - Accepted; RAM[45099]=RAM[0]; err=0.
- Reset mid-transfer: len=8; assert rst in the cycle of the 3rd WRITE.
  - No write in that cycle; only RAM[dst..dst+1] modified.
  - Next cycle: IDLE with all outputs 0.
- Start while busy plus overlap: pulse start during a transfer; it is ignored.
  - Overlap case src=10, dst=11, len=3 with RAM[10]=7.
  - Result: RAM[11..13]=7,7,7 (forward-copy smear).
